// File: rtl/tpm_mgmt_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tpm_mgmt_pkg
// Brief    : Shared TPM management constants and the command-parser state set.
// Revision : 1.0 - initial release
// ============================================================================
package tpm_mgmt_pkg;

  localparam logic [31:0] TPM_RC_SUCCESS      = 32'h0000_0000;
  localparam logic [31:0] TPM_RC_BAD_TAG      = 32'h0000_001E;
  localparam logic [31:0] TPM_RC_COMMAND_SIZE = 32'h0000_0142;

  localparam logic [15:0] TPM_ST_NO_SESSIONS  = 16'h8001;
  localparam logic [15:0] TPM_ST_SESSIONS     = 16'h8002;

  localparam int unsigned HDR_BYTES = 10;

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_PARAM   = 2'd1,
    S_DRAIN   = 2'd2,
    S_PRESENT = 2'd3
  } parse_state_t;

endpackage
`default_nettype wire

// File: rtl/tpm_cmd_header_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tpm_cmd_header_parser
// Brief    : Parses a big-endian TPM 2.0 command stream into one command word.
// Revision : 1.0 - initial release
// ============================================================================
module tpm_cmd_header_parser
  import tpm_mgmt_pkg::*;
#(
  parameter int unsigned PARAM_BYTES  = 5,
  parameter int unsigned MAX_CMD_SIZE = 4096
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic [7:0]                         byte_i,
  input  logic                               byte_valid_i,
  output logic                               byte_ready_o,
  input  logic [7:0]                         locality_i,
  input  logic                               abort_i,
  output logic                               cmd_valid_o,
  input  logic                               cmd_ready_i,
  output logic [15:0]                        tag_o,
  output logic [31:0]                        cmd_size_o,
  output logic [31:0]                        tpm_cc_o,
  output logic [8*PARAM_BYTES-1:0]           param_o,
  output logic [$clog2(PARAM_BYTES+1)-1:0]   param_len_o,
  output logic [7:0]                         locality_o,
  output logic [31:0]                        hdr_rc_o
);

  localparam int unsigned c_cnt_w  = $clog2(MAX_CMD_SIZE + 1);
  localparam int unsigned c_plen_w = $clog2(PARAM_BYTES + 1);

  parse_state_t              r_state;
  parse_state_t              w_next_state;
  logic [c_cnt_w-1:0]        r_byte_cnt;
  logic [c_cnt_w-1:0]        w_byte_cnt_nxt;
  logic [c_plen_w-1:0]       r_param_len;
  logic [c_plen_w-1:0]       w_param_len_nxt;
  logic [15:0]               r_tag;
  logic [31:0]               r_cmd_size;
  logic [31:0]               r_tpm_cc;
  logic [8*PARAM_BYTES-1:0]  r_param;
  logic [7:0]                r_locality;
  logic [31:0]               r_hdr_rc;

  logic w_xfer;
  logic w_last_hdr;
  logic w_cnt_done;
  logic w_size_bad;
  logic w_size_min;
  logic w_tag_ok;
  logic w_param_full;

  assign byte_ready_o    = (r_state != S_PRESENT);
  assign cmd_valid_o     = (r_state == S_PRESENT);
  assign w_xfer          = byte_valid_i && byte_ready_o;

  assign w_byte_cnt_nxt  = r_byte_cnt + 1'b1;
  assign w_param_len_nxt = r_param_len + 1'b1;
  assign w_last_hdr      = (r_byte_cnt == c_cnt_w'(HDR_BYTES - 1));
  // Counter is bounded by MAX_CMD_SIZE, so zero-extension to 32 bits is exact.
  assign w_cnt_done      = ({{(32-c_cnt_w){1'b0}}, w_byte_cnt_nxt} == r_cmd_size);
  assign w_size_bad      = (r_cmd_size < 32'(HDR_BYTES)) || (r_cmd_size > 32'(MAX_CMD_SIZE));
  assign w_size_min      = (r_cmd_size == 32'(HDR_BYTES));
  assign w_tag_ok        = (r_tag == TPM_ST_NO_SESSIONS) || (r_tag == TPM_ST_SESSIONS);
  assign w_param_full    = (w_param_len_nxt == c_plen_w'(PARAM_BYTES));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_HDR: begin
        if (w_xfer && w_last_hdr) begin
          if (w_size_bad || w_size_min) begin
            w_next_state = S_PRESENT;
          end else if (PARAM_BYTES > 0) begin
            w_next_state = S_PARAM;
          end else begin
            w_next_state = S_DRAIN;
          end
        end
      end
      S_PARAM: begin
        if (w_xfer) begin
          if (w_cnt_done) begin
            w_next_state = S_PRESENT;
          end else if (w_param_full) begin
            w_next_state = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_xfer && w_cnt_done) begin
          w_next_state = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (cmd_ready_i) begin
          w_next_state = S_HDR;
        end
      end
      default: w_next_state = S_HDR;
    endcase
    // Abort overrides every other event, including a same-cycle handshake.
    if (abort_i) begin
      w_next_state = S_HDR;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_byte_cnt  <= '0;
      r_param_len <= '0;
      r_tag       <= '0;
      r_cmd_size  <= '0;
      r_tpm_cc    <= '0;
      r_param     <= '0;
      r_locality  <= '0;
      r_hdr_rc    <= TPM_RC_SUCCESS;
    end else if (abort_i) begin
      r_byte_cnt  <= '0;
      r_param_len <= '0;
      r_param     <= '0;
      r_hdr_rc    <= TPM_RC_SUCCESS;
    end else begin
      case (r_state)
        S_HDR: begin
          if (w_xfer) begin
            r_byte_cnt <= w_byte_cnt_nxt;
            if (r_byte_cnt == '0) begin
              r_locality <= locality_i;
            end
            if (r_byte_cnt < c_cnt_w'(2)) begin
              r_tag <= {r_tag[7:0], byte_i};
            end else if (r_byte_cnt < c_cnt_w'(6)) begin
              r_cmd_size <= {r_cmd_size[23:0], byte_i};
            end else begin
              r_tpm_cc <= {r_tpm_cc[23:0], byte_i};
            end
            // Tag and size are already complete when the last header byte lands.
            if (w_last_hdr) begin
              if (w_size_bad) begin
                r_hdr_rc <= TPM_RC_COMMAND_SIZE;
              end else if (!w_tag_ok) begin
                r_hdr_rc <= TPM_RC_BAD_TAG;
              end else begin
                r_hdr_rc <= TPM_RC_SUCCESS;
              end
            end
          end
        end
        S_PARAM: begin
          if (w_xfer) begin
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_param_len <= w_param_len_nxt;
            for (int i = 0; i < PARAM_BYTES; i++) begin
              if (c_plen_w'(i) == r_param_len) begin
                r_param[8*(PARAM_BYTES-1-i) +: 8] <= byte_i;
              end
            end
          end
        end
        S_DRAIN: begin
          if (w_xfer) begin
            r_byte_cnt <= w_byte_cnt_nxt;
          end
        end
        S_PRESENT: begin
          if (cmd_ready_i) begin
            r_byte_cnt  <= '0;
            r_param_len <= '0;
            r_param     <= '0;
          end
        end
        default: begin
          r_byte_cnt <= '0;
        end
      endcase
    end
  end

  assign tag_o       = r_tag;
  assign cmd_size_o  = r_cmd_size;
  assign tpm_cc_o    = r_tpm_cc;
  assign param_o     = r_param;
  assign param_len_o = r_param_len;
  assign locality_o  = r_locality;
  assign hdr_rc_o    = r_hdr_rc;

endmodule
`default_nettype wire

// File: tb/tb_tpm_cmd_header_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tpm_cmd_header_parser
// Brief    : Directed self-checking bench for tpm_cmd_header_parser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpm_cmd_header_parser;

  localparam int unsigned c_pb = 5;

  logic                            clock_i = 1'b0;
  logic                            reset_i;
  logic [7:0]                      byte_i;
  logic                            byte_valid_i;
  logic                            byte_ready_o;
  logic [7:0]                      locality_i;
  logic                            abort_i;
  logic                            cmd_valid_o;
  logic                            cmd_ready_i;
  logic [15:0]                     tag_o;
  logic [31:0]                     cmd_size_o;
  logic [31:0]                     tpm_cc_o;
  logic [8*c_pb-1:0]               param_o;
  logic [$clog2(c_pb+1)-1:0]       param_len_o;
  logic [7:0]                      locality_o;
  logic [31:0]                     hdr_rc_o;

  int n_checks = 0;
  int n_errors = 0;

  tpm_cmd_header_parser #(.PARAM_BYTES(c_pb), .MAX_CMD_SIZE(4096)) u_dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .locality_i   (locality_i),
    .abort_i      (abort_i),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_ready_i  (cmd_ready_i),
    .tag_o        (tag_o),
    .cmd_size_o   (cmd_size_o),
    .tpm_cc_o     (tpm_cc_o),
    .param_o      (param_o),
    .param_len_o  (param_len_o),
    .locality_o   (locality_o),
    .hdr_rc_o     (hdr_rc_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int waits;
    waits = 0;
    byte_i       = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && waits < 64) begin
      @(negedge clock_i);
      waits++;
    end
    if (!byte_ready_o) check("byte_ready_timeout", 64'(byte_ready_o), 64'd1);
    @(negedge clock_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] q[$], input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      if (gaps && (i % 3 == 1)) @(negedge clock_i);
      if (i == q.size() - 1) check("valid_before_last", 64'(cmd_valid_o), 64'd0);
      send_byte(q[i]);
    end
  endtask

  task automatic check_cmd(input string name, input logic [15:0] tag, input logic [31:0] size,
                           input logic [31:0] cc, input logic [39:0] prm, input int len,
                           input logic [31:0] rc, input logic [7:0] loc);
    check({name, "_valid"}, 64'(cmd_valid_o), 64'd1);
    check({name, "_tag"},   64'(tag_o),       64'(tag));
    check({name, "_size"},  64'(cmd_size_o),  64'(size));
    check({name, "_cc"},    64'(tpm_cc_o),    64'(cc));
    check({name, "_param"}, 64'(param_o),     64'(prm));
    check({name, "_plen"},  64'(param_len_o), 64'(len));
    check({name, "_rc"},    64'(hdr_rc_o),    64'(rc));
    check({name, "_loc"},   64'(locality_o),  64'(loc));
  endtask

  logic [7:0] q_startup[$];
  logic [7:0] q_hc[$];
  logic [7:0] q_badtag[$];
  logic [7:0] q_small[$];
  logic [7:0] q_big[$];
  logic [7:0] q_drain[$];
  logic [39:0] hold_param;
  bit          hold_ok;

  initial begin
    q_startup = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00};
    q_hc      = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h1B, 8'h00, 8'h00, 8'h01, 8'h21,
                  8'h40, 8'h00, 8'h00, 8'h0C, 8'h01,
                  8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    q_badtag  = '{8'h80, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h44, 8'hAA, 8'hBB};
    q_small   = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h01, 8'h44};
    q_big     = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 8'h00, 8'h01, 8'h44};
    q_drain   = '{8'h80, 8'h03, 8'h00, 8'h00, 8'h00, 8'h1B, 8'h00, 8'h00, 8'h01, 8'h21,
                  8'h40, 8'h00, 8'h00, 8'h0C, 8'h01, 8'h5A, 8'hA5};

    reset_i      = 1'b1;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;
    locality_i   = 8'h00;
    abort_i      = 1'b0;
    cmd_ready_i  = 1'b0;
    repeat (3) @(negedge clock_i);
    check("rst_ready", 64'(byte_ready_o), 64'd1);
    check("rst_valid", 64'(cmd_valid_o),  64'd0);
    check("rst_tag",   64'(tag_o),        64'd0);
    check("rst_param", 64'(param_o),      64'd0);
    check("rst_rc",    64'(hdr_rc_o),     64'd0);
    reset_i = 1'b0;
    @(negedge clock_i);

    // Startup with the consumer already ready: one-cycle valid pulse.
    locality_i  = 8'h03;
    cmd_ready_i = 1'b1;
    send_cmd(q_startup, 1'b0);
    check_cmd("startup", 16'h8001, 32'h0C, 32'h144, 40'h0, 2, 32'h0, 8'h03);
    @(negedge clock_i);
    check("startup_valid_fall", 64'(cmd_valid_o), 64'd0);
    check("startup_ready_back", 64'(byte_ready_o), 64'd1);
    check("startup_plen_clr",   64'(param_len_o), 64'd0);

    // HierarchyControl with gaps, then a 20-cycle hold with backpressure.
    locality_i  = 8'h02;
    cmd_ready_i = 1'b0;
    send_cmd(q_hc, 1'b1);
    check_cmd("hierctl", 16'h8001, 32'h1B, 32'h121, 40'h40_00_00_0C_01, 5, 32'h0, 8'h02);
    hold_param   = param_o;
    hold_ok      = 1'b1;
    byte_i       = 8'hFF;
    byte_valid_i = 1'b1;
    repeat (20) begin
      @(negedge clock_i);
      if (byte_ready_o || !cmd_valid_o || param_o != hold_param || tpm_cc_o != 32'h121) hold_ok = 1'b0;
    end
    check("hold_stable", 64'(hold_ok), 64'd1);
    byte_valid_i = 1'b0;
    cmd_ready_i  = 1'b1;
    @(negedge clock_i);
    check("hold_valid_fall", 64'(cmd_valid_o),  64'd0);
    check("hold_ready_back", 64'(byte_ready_o), 64'd1);

    // Bad tag: body consumed, RC flags it.
    send_cmd(q_badtag, 1'b0);
    check_cmd("badtag", 16'h8003, 32'h0C, 32'h144, 40'hAA_BB_00_00_00, 2, 32'h01E, 8'h02);
    @(negedge clock_i);

    // Abort after six header bytes, coinciding with a transfer.
    locality_i = 8'h04;
    for (int i = 0; i < 6; i++) send_byte(q_startup[i]);
    locality_i   = 8'h07;
    byte_i       = 8'h00;
    byte_valid_i = 1'b1;
    abort_i      = 1'b1;
    @(negedge clock_i);
    abort_i      = 1'b0;
    byte_valid_i = 1'b0;
    check("abort_valid", 64'(cmd_valid_o),  64'd0);
    check("abort_ready", 64'(byte_ready_o), 64'd1);
    check("abort_rc",    64'(hdr_rc_o),     64'd0);
    check("abort_loc",   64'(locality_o),   64'd4);
    locality_i = 8'h01;
    send_cmd(q_startup, 1'b0);
    check_cmd("post_abort", 16'h8001, 32'h0C, 32'h144, 40'h0, 2, 32'h0, 8'h01);
    @(negedge clock_i);

    // Undersized and oversized commands end at the header.
    send_cmd(q_small, 1'b0);
    check_cmd("size_small", 16'h8001, 32'h08, 32'h144, 40'h0, 0, 32'h142, 8'h01);
    @(negedge clock_i);
    send_cmd(q_startup, 1'b0);
    check_cmd("after_small", 16'h8001, 32'h0C, 32'h144, 40'h0, 2, 32'h0, 8'h01);
    @(negedge clock_i);
    send_cmd(q_big, 1'b0);
    check_cmd("size_big", 16'h8001, 32'h1001, 32'h144, 40'h0, 0, 32'h142, 8'h01);
    @(negedge clock_i);

    // Asynchronous reset while draining.
    for (int i = 0; i < q_drain.size(); i++) send_byte(q_drain[i]);
    check("drain_rc_pre", 64'(hdr_rc_o),    64'h01E);
    check("drain_busy",   64'(cmd_valid_o), 64'd0);
    #2 reset_i = 1'b1;
    #1;
    check("arst_valid", 64'(cmd_valid_o),  64'd0);
    check("arst_ready", 64'(byte_ready_o), 64'd1);
    check("arst_rc",    64'(hdr_rc_o),     64'd0);
    check("arst_param", 64'(param_o),      64'd0);
    check("arst_plen",  64'(param_len_o),  64'd0);
    check("arst_cc",    64'(tpm_cc_o),     64'd0);
    check("arst_loc",   64'(locality_o),   64'd0);
    @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);
    send_cmd(q_startup, 1'b0);
    check_cmd("post_reset", 16'h8001, 32'h0C, 32'h144, 40'h0, 2, 32'h0, 8'h01);
    @(negedge clock_i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
